// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: phase handshake, tick and status signals of the frame sequencer
interface frame_sequencer_if;
  logic enable;
  logic erase_done;
  logic update_done;
  logic draw_done;
  logic erase_start;
  logic update_start;
  logic draw_start;
  logic frame_tick;
  logic busy;
  logic [15:0] frame_count;
  logic [7:0] overrun_count;
  modport master (
    input  enable, erase_done, update_done, draw_done,
    output erase_start, update_start, draw_start, frame_tick, busy, frame_count, overrun_count
  );
  modport slave (
    output enable, erase_done, update_done, draw_done,
    input  erase_start, update_start, draw_start, frame_tick, busy, frame_count, overrun_count
  );
endinterface

// File: rtl/frame_sequencer.sv
// frame_sequencer: periodic erase/update/draw frame scheduler; define FRAME_OVERRUN_CNT_EN to build the saturating overrun counter
module frame_sequencer #(
  parameter int PERIOD = 21000,
  parameter int CW = 25
) (
  input logic clock,
  input logic reset,
  frame_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic fin, drop;
  always_comb begin
    next = state;
    fin = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: next = bus.frame_tick ? ERASE : IDLE;
      ERASE: begin
        next = bus.erase_done ? UPDATE : ERASE;
        drop = bus.frame_tick;
      end
      UPDATE: begin
        next = bus.update_done ? DRAW : UPDATE;
        drop = bus.frame_tick;
      end
      default: begin
        fin = bus.draw_done;
        next = fin ? (bus.frame_tick ? ERASE : IDLE) : DRAW;
        drop = bus.frame_tick && !fin;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= CW'(PERIOD - 1);
      bus.frame_tick <= 1'b0;
      bus.erase_start <= 1'b0;
      bus.update_start <= 1'b0;
      bus.draw_start <= 1'b0;
      bus.busy <= 1'b0;
      bus.frame_count <= '0;
    end else begin
      state <= next;
      if (bus.enable) cnt <= (cnt == '0) ? CW'(PERIOD - 1) : cnt - 1'b1;
      bus.frame_tick <= bus.enable && cnt == '0;
      bus.erase_start <= next == ERASE && (state != ERASE);
      bus.update_start <= next == UPDATE && state != UPDATE;
      bus.draw_start <= next == DRAW && state != DRAW;
      bus.busy <= next != IDLE;
      bus.frame_count <= bus.frame_count + 16'(fin);
    end
  end
`ifdef FRAME_OVERRUN_CNT_EN
  logic [7:0] ovr;
  always_ff @(posedge clock) begin
    if (reset) ovr <= '0;
    else if (drop && ovr != 8'hff) ovr <= ovr + 8'd1;
  end
  assign bus.overrun_count = ovr;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign bus.overrun_count = '0;
`endif
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter PERIOD, default 21000, meaning clock cycles per frame tick (legal range 4..2^25-1).
REQ-002 SHALL have parameter CW, default 25, meaning the tick down-counter width.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  meaning the tick counter runs when 1 and holds when 0.
REQ-006 SHALL have ports erase_done, update_done, draw_done  input  1 each  meaning phase-complete strobes from the sub-blocks.
REQ-007 SHALL have ports erase_start, update_start, draw_start  output  1 each  meaning one-cycle phase-launch pulses.
REQ-008 SHALL have port frame_tick  output  1  meaning a one-cycle pulse once per PERIOD enabled cycles.
REQ-009 SHALL have port busy  output  1  meaning a frame is in progress (state not IDLE).
REQ-010 SHALL have port frame_count  output  16  meaning completed frames, wrapping modulo 2^16.
REQ-011 SHALL have port overrun_count  output  8  meaning dropped frame ticks, saturating.

Function
REQ-012 Tick counter SHALL reload PERIOD-1 on reset and decrement by 1 each cycle enable=1.
REQ-013 When the counter is 0 with enable=1, the counter SHALL reload PERIOD-1 and frame_tick SHALL be 1 in the following cycle, giving exactly one tick per PERIOD enabled cycles.
REQ-014 With enable=0, the counter SHALL hold its value and frame_tick SHALL be 0; an in-progress frame SHALL run to completion.
REQ-015 FSM states SHALL be IDLE, ERASE, UPDATE and DRAW; the reset state SHALL be IDLE.
REQ-016 IDLE with frame_tick=1 SHALL go to ERASE, with erase_start=1 in the first ERASE cycle only.
REQ-017 ERASE with erase_done=1 SHALL go to UPDATE, with update_start=1 in the first UPDATE cycle only.
REQ-018 UPDATE with update_done=1 SHALL go to DRAW, with draw_start=1 in the first DRAW cycle only.
REQ-019 DRAW with draw_done=1 and frame_tick=0 SHALL go to IDLE and increment frame_count.
REQ-020 DRAW with draw_done=1 and frame_tick=1 in the same cycle SHALL increment frame_count and go directly to ERASE with erase_start=1; this SHALL NOT count as an overrun.
REQ-021 A done strobe SHALL be honoured in any cycle of its own state, including the cycle its start pulse is high.
REQ-022 A done strobe SHALL be ignored in every other state.
REQ-023 frame_tick=1 in ERASE, UPDATE or DRAW (except the REQ-020 case) SHALL be dropped: no state change, and overrun_count increments, holding at 255.
REQ-024 Start pulses SHALL be mutually exclusive and registered; each SHALL be high for exactly one cycle per phase.
REQ-025 busy SHALL be a registered output, 1 exactly while state is not IDLE.

Reset
REQ-026 While reset=1: state SHALL be IDLE, counter PERIOD-1, and frame_tick, all start outputs, busy, frame_count and overrun_count SHALL all be 0 in the next cycle.
REQ-027 Reset mid-frame SHALL abandon the frame without incrementing frame_count; done strobes arriving during or after reset SHALL be ignored until the next erase_start.

Configuration
REQ-028 Macro FRAME_OVERRUN_CNT_EN SHALL control the overrun counter.
REQ-029 With FRAME_OVERRUN_CNT_EN defined, overrun_count SHALL behave per REQ-023.
REQ-030 Without FRAME_OVERRUN_CNT_EN, overrun_count SHALL be constant 0, no counter register SHALL be built, and dropped ticks SHALL still be discarded.

Verification
REQ-031 PERIOD=8, enable=1 from reset release -> frame_tick pulses in cycles 8, 16, 24 after release.
REQ-032 Tick in IDLE; erase_done 3 cycles later, update_done 2 cycles later, draw_done 1 cycle later -> erase, update and draw start pulses 1 cycle each, busy high throughout, then frame_count=1 and busy=0.
REQ-033 PERIOD=8; hold update_done low for 20 cycles -> two ticks dropped, overrun_count=2, state stays UPDATE (macro defined); overrun_count=0 with macro undefined.
REQ-034 draw_done coincident with frame_tick -> next cycle erase_start=1, state ERASE, frame_count increments, overrun_count unchanged.
REQ-035 reset pulsed during DRAW, then draw_done asserted -> all outputs 0, state IDLE, frame_count unchanged at 0, next erase_start only after a new tick.
REQ-036 enable=0 for 5 cycles mid-count with PERIOD=8 -> tick delayed by exactly 5 cycles; 300 forced overruns -> overrun_count saturates at 255.
